// File: rtl/ecliptic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ecliptic_pkg
// Description : Shared ecliptic FPU types and constants. Holds the rounding
//               mode, FP32 layout and integer saturation values.
// Revision    : 1.0 - initial release
// ============================================================================
package ecliptic_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RTZ = 2'd1,
        RM_RDN = 2'd2,
        RM_RUP = 2'd3
    } ecliptic_rm_e;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } ecliptic_fp32_t;

    localparam logic [31:0] c_INT_SMAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] c_INT_SMIN  = 32'h8000_0000;
    localparam logic [31:0] c_INT_UMAX  = 32'hFFFF_FFFF;
    localparam logic [31:0] c_INT_ZERO  = 32'h0000_0000;
    localparam logic [8:0]  c_FP32_BIAS = 9'd127;

    // Saturation value for an invalid conversion, chosen by direction and target type.
    function automatic logic [31:0] f2i_sat(input logic i_neg, input logic i_uns);
        logic [31:0] w_val;
        if (i_uns) begin
            w_val = i_neg ? c_INT_ZERO : c_INT_UMAX;
        end else begin
            w_val = i_neg ? c_INT_SMIN : c_INT_SMAX;
        end
        return w_val;
    endfunction

endpackage : ecliptic_pkg
`default_nettype wire

// File: rtl/ecliptic_f2i_align.sv
`default_nettype none
// ============================================================================
// Module      : ecliptic_f2i_align
// Description : Combinational significand aligner for FP32-to-integer
//               conversion. Produces the 33-bit integer part plus guard,
//               sticky and overflow indications.
// Revision    : 1.0 - initial release
// ============================================================================
module ecliptic_f2i_align
    import ecliptic_pkg::*;
(
    input  logic [23:0] i_m,
    input  logic [8:0]  i_e,
    output logic [32:0] o_int,
    output logic        o_guard,
    output logic        o_sticky,
    output logic        o_ovf
);

    logic signed [8:0] w_e_s;
    logic        [8:0] w_shamt;
    logic       [56:0] w_shifted;

    assign w_e_s   = $signed(i_e);
    assign w_shamt = i_e + 9'd1;

    // The value is m * 2^(e-23). Shifting left by e+1 puts the binary point
    // at bit 24, so the top 33 bits are the integer part and bit 23 the guard.
    assign w_shifted = {33'd0, i_m} << w_shamt[5:0];

    always_comb begin
        o_int    = '0;
        o_guard  = 1'b0;
        o_sticky = 1'b0;
        o_ovf    = 1'b0;
        if (w_e_s > 9'sd31) begin
            o_ovf = 1'b1;
        end else if (w_e_s >= -9'sd1) begin
            o_int    = w_shifted[56:24];
            o_guard  = w_shifted[23];
            o_sticky = |w_shifted[22:0];
        end else begin
            o_sticky = |i_m;
        end
    end

endmodule : ecliptic_f2i_align
`default_nettype wire

// File: rtl/ecliptic_converter_to_int.sv
`default_nettype none
// ============================================================================
// Module      : ecliptic_converter_to_int
// Description : Pipelined FP32 to signed/unsigned 32-bit integer converter
//               with rounding, saturation and invalid/inexact flags.
//               ECLIPTIC_F2I_LOW_LATENCY_EN merges align and round (latency 2).
// Revision    : 1.0 - initial release
// ============================================================================
module ecliptic_converter_to_int
    import ecliptic_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic        req,
    input  logic [31:0] src,
    input  logic [1:0]  rm,
    input  logic        dst_unsigned,
    output logic        ack,
    output logic [31:0] res,
    output logic        invalid,
    output logic        inexact
);

    // ---------------- operand capture ----------------
    logic           r_s0_vld;
    ecliptic_fp32_t r_s0_src;
    ecliptic_rm_e   r_s0_rm;
    logic           r_s0_uns;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_s0_vld <= 1'b0;
            r_s0_src <= '0;
            r_s0_rm  <= RM_RNE;
            r_s0_uns <= 1'b0;
        end else begin
            r_s0_vld <= req;
            if (req) begin
                r_s0_src <= src;
                r_s0_rm  <= ecliptic_rm_e'(rm);
                r_s0_uns <= dst_unsigned;
            end
        end
    end

    // ---------------- stage 1: decode ----------------
    logic [8:0]  w_d_e;
    logic [23:0] w_d_m;
    logic        w_d_nan;
    logic        w_d_inf;

    assign w_d_e   = {1'b0, r_s0_src.exp} - c_FP32_BIAS;
    assign w_d_m   = {(r_s0_src.exp != 8'd0), r_s0_src.frac};
    assign w_d_nan = (r_s0_src.exp == 8'hFF) && (r_s0_src.frac != 23'd0);
    assign w_d_inf = (r_s0_src.exp == 8'hFF) && (r_s0_src.frac == 23'd0);

    logic         r_s1_vld;
    logic         r_s1_sign;
    logic [8:0]   r_s1_e;
    logic [23:0]  r_s1_m;
    logic         r_s1_nan;
    logic         r_s1_inf;
    ecliptic_rm_e r_s1_rm;
    logic         r_s1_uns;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_s1_vld  <= 1'b0;
            r_s1_sign <= 1'b0;
            r_s1_e    <= '0;
            r_s1_m    <= '0;
            r_s1_nan  <= 1'b0;
            r_s1_inf  <= 1'b0;
            r_s1_rm   <= RM_RNE;
            r_s1_uns  <= 1'b0;
        end else begin
            r_s1_vld <= r_s0_vld;
            if (r_s0_vld) begin
                r_s1_sign <= r_s0_src.sign;
                r_s1_e    <= w_d_e;
                r_s1_m    <= w_d_m;
                r_s1_nan  <= w_d_nan;
                r_s1_inf  <= w_d_inf;
                r_s1_rm   <= r_s0_rm;
                r_s1_uns  <= r_s0_uns;
            end
        end
    end

    // ---------------- stage 2: align ----------------
    logic [32:0] w_a_int;
    logic        w_a_guard;
    logic        w_a_sticky;
    logic        w_a_ovf;

    ecliptic_f2i_align u_align (
        .i_m      (r_s1_m),
        .i_e      (r_s1_e),
        .o_int    (w_a_int),
        .o_guard  (w_a_guard),
        .o_sticky (w_a_sticky),
        .o_ovf    (w_a_ovf)
    );

    logic         w_r_vld;
    logic         w_r_sign;
    logic [32:0]  w_r_int;
    logic         w_r_guard;
    logic         w_r_sticky;
    logic         w_r_ovf;
    logic         w_r_nan;
    logic         w_r_inf;
    ecliptic_rm_e w_r_rm;
    logic         w_r_uns;

`ifdef ECLIPTIC_F2I_LOW_LATENCY_EN
    // Align feeds rounding directly in the same cycle.
    assign w_r_vld    = r_s1_vld;
    assign w_r_sign   = r_s1_sign;
    assign w_r_int    = w_a_int;
    assign w_r_guard  = w_a_guard;
    assign w_r_sticky = w_a_sticky;
    assign w_r_ovf    = w_a_ovf;
    assign w_r_nan    = r_s1_nan;
    assign w_r_inf    = r_s1_inf;
    assign w_r_rm     = r_s1_rm;
    assign w_r_uns    = r_s1_uns;
`else
    logic         r_s2_vld;
    logic         r_s2_sign;
    logic [32:0]  r_s2_int;
    logic         r_s2_guard;
    logic         r_s2_sticky;
    logic         r_s2_ovf;
    logic         r_s2_nan;
    logic         r_s2_inf;
    ecliptic_rm_e r_s2_rm;
    logic         r_s2_uns;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_s2_vld    <= 1'b0;
            r_s2_sign   <= 1'b0;
            r_s2_int    <= '0;
            r_s2_guard  <= 1'b0;
            r_s2_sticky <= 1'b0;
            r_s2_ovf    <= 1'b0;
            r_s2_nan    <= 1'b0;
            r_s2_inf    <= 1'b0;
            r_s2_rm     <= RM_RNE;
            r_s2_uns    <= 1'b0;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_sign   <= r_s1_sign;
                r_s2_int    <= w_a_int;
                r_s2_guard  <= w_a_guard;
                r_s2_sticky <= w_a_sticky;
                r_s2_ovf    <= w_a_ovf;
                r_s2_nan    <= r_s1_nan;
                r_s2_inf    <= r_s1_inf;
                r_s2_rm     <= r_s1_rm;
                r_s2_uns    <= r_s1_uns;
            end
        end
    end

    assign w_r_vld    = r_s2_vld;
    assign w_r_sign   = r_s2_sign;
    assign w_r_int    = r_s2_int;
    assign w_r_guard  = r_s2_guard;
    assign w_r_sticky = r_s2_sticky;
    assign w_r_ovf    = r_s2_ovf;
    assign w_r_nan    = r_s2_nan;
    assign w_r_inf    = r_s2_inf;
    assign w_r_rm     = r_s2_rm;
    assign w_r_uns    = r_s2_uns;
`endif

    // ---------------- stage 3: round / saturate ----------------
    logic        w_rnd_up;
    logic [32:0] w_mag;
    logic        w_range_fail;
    logic        w_inv;
    logic        w_inx;
    logic [31:0] w_res;

    always_comb begin
        w_rnd_up = 1'b0;
        case (w_r_rm)
            RM_RNE:  w_rnd_up = w_r_guard & (w_r_sticky | w_r_int[0]);
            RM_RTZ:  w_rnd_up = 1'b0;
            RM_RDN:  w_rnd_up = w_r_sign & (w_r_guard | w_r_sticky);
            RM_RUP:  w_rnd_up = ~w_r_sign & (w_r_guard | w_r_sticky);
            default: w_rnd_up = 1'b0;
        endcase
    end

    assign w_mag = w_r_int + {32'd0, w_rnd_up};

    always_comb begin
        w_range_fail = w_r_ovf;
        if (w_r_uns) begin
            // Negative inputs are only legal if they round to zero.
            w_range_fail = w_range_fail | w_mag[32] | (w_r_sign & (w_mag != 33'd0));
        end else if (w_r_sign) begin
            w_range_fail = w_range_fail | (w_mag > 33'h0_8000_0000);
        end else begin
            w_range_fail = w_range_fail | (w_mag > 33'h0_7FFF_FFFF);
        end
    end

    assign w_inv = w_r_nan | w_r_inf | w_range_fail;
    assign w_inx = ~w_inv & (w_r_guard | w_r_sticky);

    always_comb begin
        w_res = w_mag[31:0];
        if (w_r_nan) begin
            w_res = f2i_sat(1'b0, w_r_uns);
        end else if (w_inv) begin
            w_res = f2i_sat(w_r_sign, w_r_uns);
        end else if (!w_r_uns && w_r_sign) begin
            w_res = -w_mag[31:0];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ack     <= 1'b0;
            res     <= '0;
            invalid <= 1'b0;
            inexact <= 1'b0;
        end else begin
            ack     <= w_r_vld;
            res     <= w_r_vld ? w_res : '0;
            invalid <= w_r_vld & w_inv;
            inexact <= w_r_vld & w_inx;
        end
    end

endmodule : ecliptic_converter_to_int
`default_nettype wire

// File: tb/tb_ecliptic_converter_to_int.sv
`default_nettype none
// ============================================================================
// Module      : tb_ecliptic_converter_to_int
// Description : Self-checking bench for the FP32-to-integer converter: directed
//               table, pipeline/reset sequences and randomized model checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ecliptic_converter_to_int;

`ifdef ECLIPTIC_F2I_LOW_LATENCY_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        nrst;
    logic        req;
    logic [31:0] src;
    logic [1:0]  rm;
    logic        dst_unsigned;
    logic        ack;
    logic [31:0] res;
    logic        invalid;
    logic        inexact;

    always #5 clk = ~clk;

    ecliptic_converter_to_int dut (
        .clk          (clk),
        .nrst         (nrst),
        .req          (req),
        .src          (src),
        .rm           (rm),
        .dst_unsigned (dst_unsigned),
        .ack          (ack),
        .res          (res),
        .invalid      (invalid),
        .inexact      (inexact)
    );

    typedef struct {
        logic [31:0] src;
        logic [1:0]  rm;
        logic        uns;
        logic [31:0] res;
        logic        inv;
        logic        inx;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] src;
        logic [31:0] res;
        logic        inv;
        logic        inx;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle: either an expected result is due, or the outputs must be idle.
    always @(negedge clk) begin
        if (sb.size() != 0 && sb[0].due <= cyc) begin
            m_e = sb.pop_front();
            n_vec++;
            if (!(ack === 1'b1 && res === m_e.res && invalid === m_e.inv && inexact === m_e.inx)) begin
                n_bad++;
                $display("FAIL result src=%h cyc=%0d: got ack=%b res=%h inv=%b inx=%b, want ack=1 res=%h inv=%b inx=%b",
                         m_e.src, cyc, ack, res, invalid, inexact, m_e.res, m_e.inv, m_e.inx);
            end
        end else begin
            n_vec++;
            if ({ack, res, invalid, inexact} !== 35'd0) begin
                n_bad++;
                $display("FAIL idle cyc=%0d: got ack=%b res=%h inv=%b inx=%b, want all zero",
                         cyc, ack, res, invalid, inexact);
            end
        end
    end

    task automatic issue(input logic [31:0] s, input logic [1:0] r, input logic u,
                         input logic [31:0] er, input logic ei, input logic ex);
        exp_t e;
        @(negedge clk);
        req          = 1'b1;
        src          = s;
        rm           = r;
        dst_unsigned = u;
        e.due = cyc + 1 + LAT;
        e.src = s;
        e.res = er;
        e.inv = ei;
        e.inx = ex;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req          = 1'b0;
            src          = $urandom;
            rm           = 2'($urandom_range(0, 3));
            dst_unsigned = 1'($urandom_range(0, 1));
        end
    endtask

    // Reference: exact real value of the operand, rounded with floor/ceil arithmetic.
    function automatic void model(input logic [31:0] s, input logic [1:0] r, input logic u,
                                  output logic [31:0] o_res, output logic o_inv, output logic o_inx);
        real    v, f, d, rr;
        longint ri;
        logic   nan, inf, neg, even, inrange;
        nan  = (s[30:23] == 8'hFF) && (s[22:0] != 23'd0);
        inf  = (s[30:23] == 8'hFF) && (s[22:0] == 23'd0);
        neg  = s[31];
        if (s[30:23] == 8'd0) v = real'(s[22:0]) * (2.0 ** (-149.0));
        else v = real'({1'b1, s[22:0]}) * (2.0 ** (real'(int'(s[30:23])) - 150.0));
        if (neg) v = -v;
        f = $floor(v);
        d = v - f;
        even = 1'b1;
        if (f > -1.0e15 && f < 1.0e15) even = ((longint'(f) % 2) == 0);
        case (r)
            2'd0:    rr = (d > 0.5) ? f + 1.0 : (d < 0.5) ? f : (even ? f : f + 1.0);
            2'd1:    rr = (v < 0.0) ? $ceil(v) : $floor(v);
            2'd2:    rr = $floor(v);
            default: rr = $ceil(v);
        endcase
        inrange = u ? (rr >= 0.0 && rr <= 4294967295.0)
                    : (rr >= -2147483648.0 && rr <= 2147483647.0);
        o_inx = 1'b0;
        if (nan) begin
            o_inv = 1'b1;
            o_res = u ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
        end else if (inf || !inrange) begin
            o_inv = 1'b1;
            o_res = neg ? (u ? 32'h0 : 32'h8000_0000) : (u ? 32'hFFFF_FFFF : 32'h7FFF_FFFF);
        end else begin
            o_inv = 1'b0;
            ri    = longint'(rr);
            o_res = ri[31:0];
            o_inx = (rr != v);
        end
    endfunction

    vec_t        tbl[$];
    logic [31:0] g_src;
    logic [1:0]  g_rm;
    logic        g_uns;
    logic [31:0] g_res;
    logic        g_inv;
    logic        g_inx;

    initial begin
        nrst = 1'b0; req = 1'b0; src = '0; rm = '0; dst_unsigned = 1'b0;
        //            src            rm    uns   res            inv   inx
        tbl.push_back('{32'h3FC0_0000, 2'd0, 1'b0, 32'h0000_0002, 1'b0, 1'b1});
        tbl.push_back('{32'h3FC0_0000, 2'd1, 1'b0, 32'h0000_0001, 1'b0, 1'b1});
        tbl.push_back('{32'hC020_0000, 2'd0, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1});
        tbl.push_back('{32'hC020_0000, 2'd2, 1'b0, 32'hFFFF_FFFD, 1'b0, 1'b1});
        tbl.push_back('{32'hC020_0000, 2'd3, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1});
        tbl.push_back('{32'h4F00_0000, 2'd0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0});
        tbl.push_back('{32'h4F00_0000, 2'd0, 1'b1, 32'h8000_0000, 1'b0, 1'b0});
        tbl.push_back('{32'hCF00_0000, 2'd0, 1'b0, 32'h8000_0000, 1'b0, 1'b0});
        tbl.push_back('{32'hCF00_0001, 2'd1, 1'b0, 32'h8000_0000, 1'b1, 1'b0});
        tbl.push_back('{32'h7FC0_0000, 2'd0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0});
        tbl.push_back('{32'h7FC0_0000, 2'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0});
        tbl.push_back('{32'hFF80_0000, 2'd0, 1'b1, 32'h0000_0000, 1'b1, 1'b0});
        tbl.push_back('{32'hFF80_0000, 2'd0, 1'b0, 32'h8000_0000, 1'b1, 1'b0});
        tbl.push_back('{32'h7F80_0000, 2'd1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0});
        tbl.push_back('{32'hBE99_999A, 2'd1, 1'b1, 32'h0000_0000, 1'b0, 1'b1});
        tbl.push_back('{32'hBF80_0000, 2'd0, 1'b1, 32'h0000_0000, 1'b1, 1'b0});
        tbl.push_back('{32'h8000_0000, 2'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b0});
        tbl.push_back('{32'h0000_0000, 2'd3, 1'b1, 32'h0000_0000, 1'b0, 1'b0});
        tbl.push_back('{32'h4F80_0000, 2'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0});
        tbl.push_back('{32'h4F7F_FFFF, 2'd0, 1'b1, 32'hFFFF_FF00, 1'b0, 1'b0});
        tbl.push_back('{32'h3F00_0000, 2'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b1});
        tbl.push_back('{32'h3F00_0000, 2'd3, 1'b0, 32'h0000_0001, 1'b0, 1'b1});
        tbl.push_back('{32'hBF00_0000, 2'd2, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1});
        tbl.push_back('{32'h0000_0001, 2'd3, 1'b0, 32'h0000_0001, 1'b0, 1'b1});
        tbl.push_back('{32'h4040_0000, 2'd0, 1'b0, 32'h0000_0003, 1'b0, 1'b0});

        repeat (3) @(negedge clk);
        nrst = 1'b1;
        idle(2);

        for (int i = 0; i < tbl.size(); i++) begin
            issue(tbl[i].src, tbl[i].rm, tbl[i].uns, tbl[i].res, tbl[i].inv, tbl[i].inx);
            idle(1);
        end
        idle(LAT + 2);

        // Back-to-back issue: three consecutive acks.
        issue(32'h3F80_0000, 2'd0, 1'b0, 32'd1, 1'b0, 1'b0);
        issue(32'h4000_0000, 2'd0, 1'b0, 32'd2, 1'b0, 1'b0);
        issue(32'h4040_0000, 2'd0, 1'b0, 32'd3, 1'b0, 1'b0);
        idle(LAT + 2);

        // Reset one cycle after the second request: both operations vanish.
        issue(32'h3F80_0000, 2'd0, 1'b0, 32'd1, 1'b0, 1'b0);
        issue(32'h4000_0000, 2'd0, 1'b0, 32'd2, 1'b0, 1'b0);
        @(negedge clk);
        req  = 1'b0;
        nrst = 1'b0;
        sb.delete();
        @(negedge clk);
        nrst = 1'b1;
        idle(LAT + 5);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                case ($urandom_range(0, 9))
                    0:       g_src = $urandom;
                    1:       g_src = {1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00,
                                      ($urandom_range(0, 1) != 0) ? 23'd0 : 23'($urandom)};
                    default: g_src = {1'($urandom_range(0, 1)), 8'($urandom_range(115, 160)), 23'($urandom)};
                endcase
                if ($urandom_range(0, 2) == 0) g_src[19:0] = '0;
                g_rm  = 2'($urandom_range(0, 3));
                g_uns = 1'($urandom_range(0, 1));
                model(g_src, g_rm, g_uns, g_res, g_inv, g_inx);
                issue(g_src, g_rm, g_uns, g_res, g_inv, g_inx);
            end
        end
        idle(LAT + 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_ecliptic_converter_to_int
`default_nettype wire
